// File: rtl/sonuc_toplayici_pkg.sv
// Shared types and constants for the pipeline result collector.
// State encodings, default frame size and word widths.
package sonuc_toplayici_pkg;

   typedef enum logic [1:0] {
      BOSTA  = 2'd0,
      TOPLA  = 2'd1,
      BOSALT = 2'd2,
      BITTI  = 2'd3
   } durum_t;

   localparam int VARSAYILAN_GENISLIK  = 320;
   localparam int VARSAYILAN_YUKSEKLIK = 240;
   localparam int KELIME_GEN           = 32;
   localparam int FIFO_GIRDI_GEN       = 2 * KELIME_GEN;
   localparam int SAYAC_GEN            = 17;

   // Byte address of word k within the frame buffer.
   function automatic logic [KELIME_GEN-1:0] kelime_adresi(
      input logic [KELIME_GEN-1:0] taban,
      input logic [SAYAC_GEN-1:0]  idx
   );
      return taban + (32'(idx) * 32'd4);
   endfunction

endpackage

// File: rtl/sonuc_toplayici_kelime_fifo.sv
// Synchronous word FIFO holding {address, data} pairs; a push into a full
// FIFO is accepted only when a pop happens on the same edge.
module kelime_fifo
   import sonuc_toplayici_pkg::*;
#(
   parameter int DERINLIK = 8,
   parameter int GEN      = FIFO_GIRDI_GEN
) (
   input  logic           i_clk,
   input  logic           i_rstn,
   input  logic           i_temizle,
   input  logic           i_yaz,
   input  logic           i_oku,
   input  logic [GEN-1:0] i_veri,
   output logic [GEN-1:0] o_veri,
   output logic           o_dolu,
   output logic           o_bos
);

   localparam int AW = $clog2(DERINLIK);

   logic [GEN-1:0] r_bellek [DERINLIK];
   logic [AW-1:0]  r_yaz_ptr;
   logic [AW-1:0]  r_oku_ptr;
   logic [AW:0]    r_sayi;
   logic           w_yaz;
   logic           w_oku;

   assign o_bos  = (r_sayi == '0);
   assign o_dolu = (r_sayi == (AW+1)'(DERINLIK));
   assign w_oku  = i_oku && !o_bos;
   assign w_yaz  = i_yaz && (!o_dolu || w_oku);
   assign o_veri = r_bellek[r_oku_ptr];

   // Pointer and occupancy bookkeeping
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_yaz_ptr <= '0;
         r_oku_ptr <= '0;
         r_sayi    <= '0;
      end else if (i_temizle) begin
         r_yaz_ptr <= '0;
         r_oku_ptr <= '0;
         r_sayi    <= '0;
      end else begin
         if (w_yaz) r_yaz_ptr <= r_yaz_ptr + AW'(1'b1);
         if (w_oku) r_oku_ptr <= r_oku_ptr + AW'(1'b1);
         case ({w_yaz, w_oku})
            2'b10:   r_sayi <= r_sayi + (AW+1)'(1'b1);
            2'b01:   r_sayi <= r_sayi - (AW+1)'(1'b1);
            default: r_sayi <= r_sayi;
         endcase
      end
   end

   // Storage array; contents are only meaningful below the occupancy count
   always_ff @(posedge i_clk) begin
      if (w_yaz) r_bellek[r_yaz_ptr] <= i_veri;
   end

endmodule

// File: rtl/sonuc_toplayici.sv
// Pixel stream sink: packs 4 pixels per word and writes them to a frame buffer.
// Optional frame checksum output enabled by the TOPLAYICI_SAGLAMA_EN macro.
module sonuc_toplayici
   import sonuc_toplayici_pkg::*;
#(
   parameter int          GENISLIK      = VARSAYILAN_GENISLIK,
   parameter int          YUKSEKLIK     = VARSAYILAN_YUKSEKLIK,
   parameter int          FIFO_DERINLIK = 8,
   parameter logic [31:0] TABAN_ADRES   = 32'h0000_0000
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  baslat_i,
   input  logic                  veri_etkin_i,
   input  logic [7:0]            veri_i,
   output logic                  bellek_istek_o,
   output logic [KELIME_GEN-1:0] bellek_adres_o,
   output logic [KELIME_GEN-1:0] bellek_veri_o,
   input  logic                  bellek_hazir_i,
   output logic                  cerceve_bitti_o,
   output logic                  tasma_o,
   output logic [SAYAC_GEN-1:0]  piksel_sayac_o
`ifdef TOPLAYICI_SAGLAMA_EN
   ,
   output logic [31:0]           saglama_o
`endif
);

   localparam logic [SAYAC_GEN-1:0] PIKSEL_SAYI = SAYAC_GEN'(GENISLIK * YUKSEKLIK);
   localparam logic [SAYAC_GEN-1:0] KELIME_SAYI = SAYAC_GEN'(GENISLIK * YUKSEKLIK / 4);

   durum_t                    r_durum;
   durum_t                    w_sonraki;
   logic [SAYAC_GEN-1:0]      r_sayac;
   logic [SAYAC_GEN-1:0]      r_kelime_idx;
   logic [1:0]                r_slot;
   logic [23:0]               r_paket;
   logic                      r_tasma;
   logic                      w_baslat;
   logic                      w_piksel_al;
   logic                      w_kelime_tamam;
   logic                      w_pop;
   logic                      w_push;
   logic                      w_dolu;
   logic                      w_bos;
   logic [FIFO_GIRDI_GEN-1:0] w_fifo_giris;
   logic [FIFO_GIRDI_GEN-1:0] w_fifo_cikis;

   assign w_baslat       = baslat_i && ((r_durum == BOSTA) || (r_durum == BITTI));
   assign w_piksel_al    = (r_durum == TOPLA) && veri_etkin_i;
   assign w_kelime_tamam = w_piksel_al && (r_slot == 2'd3);
   assign w_pop          = !w_bos && bellek_hazir_i;
   assign w_push         = w_kelime_tamam && (!w_dolu || w_pop);
   assign w_fifo_giris   = {kelime_adresi(TABAN_ADRES, r_kelime_idx), veri_i, r_paket};

   kelime_fifo #(
      .DERINLIK (FIFO_DERINLIK),
      .GEN      (FIFO_GIRDI_GEN)
   ) u_kelime_fifo (
      .i_clk     (clk_i),
      .i_rstn    (rstn_i),
      .i_temizle (w_baslat),
      .i_yaz     (w_push),
      .i_oku     (w_pop),
      .i_veri    (w_fifo_giris),
      .o_veri    (w_fifo_cikis),
      .o_dolu    (w_dolu),
      .o_bos     (w_bos)
   );

   // State register
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) r_durum <= BOSTA;
      else         r_durum <= w_sonraki;
   end

   // Next-state logic; the last pixel moves straight to draining so no extra pixel slips in
   always_comb begin
      w_sonraki = r_durum;
      case (r_durum)
         BOSTA:   if (baslat_i) w_sonraki = TOPLA;  else w_sonraki = BOSTA;
         TOPLA:   if (w_piksel_al && (r_sayac == PIKSEL_SAYI - 17'd1)) w_sonraki = BOSALT;
                  else w_sonraki = TOPLA;
         BOSALT:  if (w_bos) w_sonraki = BITTI;     else w_sonraki = BOSALT;
         BITTI:   if (baslat_i) w_sonraki = TOPLA;  else w_sonraki = BITTI;
         default: w_sonraki = BOSTA;
      endcase
   end

   // Pixel counter, pack register, word index and overflow flag
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_sayac      <= '0;
         r_kelime_idx <= '0;
         r_slot       <= 2'd0;
         r_paket      <= 24'd0;
         r_tasma      <= 1'b0;
      end else if (w_baslat) begin
         r_sayac      <= '0;
         r_kelime_idx <= '0;
         r_slot       <= 2'd0;
         r_paket      <= 24'd0;
         r_tasma      <= 1'b0;
      end else if (w_piksel_al) begin
         r_sayac <= r_sayac + 17'd1;
         r_slot  <= r_slot + 2'd1;
         case (r_slot)
            2'd0:    r_paket[7:0]   <= veri_i;
            2'd1:    r_paket[15:8]  <= veri_i;
            2'd2:    r_paket[23:16] <= veri_i;
            default: r_paket        <= r_paket;
         endcase
         // A dropped word still takes its address slot
         if (w_kelime_tamam) begin
            if (r_kelime_idx == KELIME_SAYI - 17'd1) r_kelime_idx <= '0;
            else                                      r_kelime_idx <= r_kelime_idx + 17'd1;
            r_tasma <= r_tasma | (w_dolu && !w_pop);
         end
      end
   end

`ifdef TOPLAYICI_SAGLAMA_EN
   logic [31:0] r_saglama;

   // Running sum of accepted pixels
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)          r_saglama <= 32'd0;
      else if (w_baslat)    r_saglama <= 32'd0;
      else if (w_piksel_al) r_saglama <= r_saglama + 32'(veri_i);
   end

   assign saglama_o = r_saglama;
`endif

   assign bellek_istek_o  = !w_bos;
   assign bellek_adres_o  = w_bos ? TABAN_ADRES : w_fifo_cikis[63:32];
   assign bellek_veri_o   = w_bos ? 32'd0 : w_fifo_cikis[31:0];
   assign cerceve_bitti_o = (r_durum == BITTI);
   assign tasma_o         = r_tasma;
   assign piksel_sayac_o  = r_sayac;

endmodule

// File: tb/tb_sonuc_toplayici.sv
// Randomized bench for sonuc_toplayici against a queue-based behavioural model.
module tb_sonuc_toplayici;

   localparam int          G     = 16;
   localparam int          Y     = 4;
   localparam int          D     = 8;
   localparam int          N     = G * Y;
   localparam int          NW    = N / 4;
   localparam logic [31:0] TABAN = 32'h0000_1000;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic        baslat_i;
   logic        veri_etkin_i;
   logic [7:0]  veri_i;
   logic        bellek_istek_o;
   logic [31:0] bellek_adres_o;
   logic [31:0] bellek_veri_o;
   logic        bellek_hazir_i;
   logic        cerceve_bitti_o;
   logic        tasma_o;
   logic [16:0] piksel_sayac_o;
`ifdef TOPLAYICI_SAGLAMA_EN
   logic [31:0] saglama_o;
`endif

   always #5 clk_i = ~clk_i;

   sonuc_toplayici #(
      .GENISLIK      (G),
      .YUKSEKLIK     (Y),
      .FIFO_DERINLIK (D),
      .TABAN_ADRES   (TABAN)
   ) dut (
      .clk_i           (clk_i),
      .rstn_i          (rstn_i),
      .baslat_i        (baslat_i),
      .veri_etkin_i    (veri_etkin_i),
      .veri_i          (veri_i),
      .bellek_istek_o  (bellek_istek_o),
      .bellek_adres_o  (bellek_adres_o),
      .bellek_veri_o   (bellek_veri_o),
      .bellek_hazir_i  (bellek_hazir_i),
      .cerceve_bitti_o (cerceve_bitti_o),
      .tasma_o         (tasma_o),
      .piksel_sayac_o  (piksel_sayac_o)
`ifdef TOPLAYICI_SAGLAMA_EN
      ,
      .saglama_o       (saglama_o)
`endif
   );

   int n_kontrol = 0;
   int n_hata    = 0;

   // Model: phase 0 idle, 1 collecting, 2 draining, 3 done
   int          m_faz;
   int          m_say;
   int          m_k;
   bit          m_tasma;
   logic [31:0] m_sag;
   logic [7:0]  m_grup[$];
   logic [7:0]  m_pix[$];
   logic [63:0] mq[$];
   logic [31:0] goruntu[int];
   int          yazma_say;
   logic [31:0] son_adres;

   task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
      n_kontrol++;
      if (gozlenen !== beklenen) begin
         n_hata++;
         $display("FAIL %s: gozlenen=%h beklenen=%h t=%0t", etiket, gozlenen, beklenen, $time);
      end
   endtask

   task automatic modeli_temizle();
      m_say = 0; m_k = 0; m_tasma = 0; m_sag = 32'd0;
      m_grup.delete(); m_pix.delete(); mq.delete(); goruntu.delete();
      yazma_say = 0;
   endtask

   function automatic bit hazir_sec(input int mod, input int c);
      case (mod)
         0:       return 1'b1;
         1:       return (c % 4) == 0;
         2:       return !(c >= 8 && c < 48);
         default: return 1'($urandom % 2);
      endcase
   endfunction

   // One clock: drive, check at the falling edge, then advance the model over the rising edge
   task automatic adim(input bit baslat, input bit etkin, input logic [7:0] px, input bit hazir);
      bit          pop, dolu, bos_once;
      logic [31:0] kelime;
      baslat_i = baslat; veri_etkin_i = etkin; veri_i = px; bellek_hazir_i = hazir;
      @(negedge clk_i);
      kontrol("istek", 32'(bellek_istek_o), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
         kontrol("adres", bellek_adres_o, mq[0][63:32]);
         kontrol("veri", bellek_veri_o, mq[0][31:0]);
      end else begin
         kontrol("adres_bos", bellek_adres_o, TABAN);
         kontrol("veri_bos", bellek_veri_o, 32'd0);
      end
      kontrol("bitti", 32'(cerceve_bitti_o), 32'(m_faz == 3));
      kontrol("tasma", 32'(tasma_o), 32'(m_tasma));
      kontrol("sayac", 32'(piksel_sayac_o), 32'(m_say));
      if (bellek_istek_o && hazir) begin
         goruntu[int'((bellek_adres_o - TABAN) >> 2)] = bellek_veri_o;
         son_adres = bellek_adres_o;
         yazma_say++;
      end
      bos_once = (mq.size() == 0);
      dolu     = (mq.size() == D);
      pop      = !bos_once && hazir;
      if (pop) void'(mq.pop_front());
      if ((m_faz == 0 || m_faz == 3) && baslat) begin
         modeli_temizle();
         m_faz = 1;
      end else if (m_faz == 1 && etkin) begin
         m_say++;
         m_sag += 32'(px);
         m_pix.push_back(px);
         m_grup.push_back(px);
         if (m_grup.size() == 4) begin
            kelime = {m_grup[3], m_grup[2], m_grup[1], m_grup[0]};
            if (!dolu || pop) mq.push_back({TABAN + 32'(m_k) * 32'd4, kelime});
            else              m_tasma = 1'b1;
            m_k = (m_k + 1) % NW;
            m_grup.delete();
         end
         if (m_say == N) m_faz = 2;
      end else if (m_faz == 2 && bos_once) begin
         m_faz = 3;
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic cerceve_kos(input int hz_mod, input int veri_mod, input bit bosluk);
      int   c = 0;
      int   i = 0;
      int   sinir = 0;
      bit   etkin;
      logic [7:0] px;
      adim(1'b1, 1'b0, 8'd0, hazir_sec(hz_mod, c));
      c++;
      while (i < N) begin
         etkin = bosluk ? ($urandom % 4 != 0) : 1'b1;
         px = (veri_mod == 0) ? 8'(i) : (veri_mod == 1) ? 8'($urandom) : 8'hFF;
         adim((veri_mod == 1) && ($urandom % 16 == 0), etkin, px, hazir_sec(hz_mod, c));
         if (etkin) i++;
         c++;
      end
      while (m_faz != 3 && sinir < 400) begin
         adim(1'b0, 1'b0, 8'd0, hazir_sec(hz_mod, c));
         c++;
         sinir++;
      end
      if (sinir >= 400) kontrol("bosaltma_zaman", 32'(cerceve_bitti_o), 32'd1);
      adim(1'b0, 1'b0, 8'd0, 1'b1);
   endtask

   task automatic goruntu_kontrol(input bit tam);
      logic [31:0] bek;
      for (int k = 0; k < NW; k++) begin
         bek = {m_pix[4*k+3], m_pix[4*k+2], m_pix[4*k+1], m_pix[4*k]};
         if (tam) kontrol($sformatf("var_%0d", k), 32'(goruntu.exists(k)), 32'd1);
         if (goruntu.exists(k)) kontrol($sformatf("kelime_%0d", k), goruntu[k], bek);
      end
      if (tam) kontrol("yazma_sayisi", 32'(yazma_say), 32'(NW));
   endtask

   initial begin
      int yaz0;
      rstn_i = 1'b0; baslat_i = 1'b0; veri_etkin_i = 1'b0; veri_i = 8'd0; bellek_hazir_i = 1'b1;
      m_faz = 0;
      modeli_temizle();
      repeat (2) @(posedge clk_i);
      #1;
      kontrol("rst_istek", 32'(bellek_istek_o), 32'd0);
      kontrol("rst_adres", bellek_adres_o, TABAN);
      kontrol("rst_veri", bellek_veri_o, 32'd0);
      kontrol("rst_bitti", 32'(cerceve_bitti_o), 32'd0);
      kontrol("rst_tasma", 32'(tasma_o), 32'd0);
      kontrol("rst_sayac", 32'(piksel_sayac_o), 32'd0);
      rstn_i = 1'b1;

      // Pixels before start are dropped
      repeat (4) adim(1'b0, 1'b1, 8'($urandom), 1'b1);

      // Index pattern, memory always ready
      cerceve_kos(0, 0, 1'b0);
      goruntu_kontrol(1'b1);
      if (goruntu.exists(0)) kontrol("kelime0_sabit", goruntu[0], 32'h0302_0100);
      if (goruntu.exists(1)) kontrol("kelime1_sabit", goruntu[1], 32'h0706_0504);
      kontrol("son_adres", son_adres, TABAN + 32'(4 * (NW - 1)));
      kontrol("son_sayac", 32'(piksel_sayac_o), 32'(N));
      yaz0 = yazma_say;
      repeat (5) adim(1'b0, 1'b1, 8'($urandom), 1'b1);
      kontrol("ek_yazma", 32'(yazma_say), 32'(yaz0));

      // Memory ready one cycle in four
      cerceve_kos(1, 1, 1'b0);
      goruntu_kontrol(1'b1);

      // Long stall forces overflow
      cerceve_kos(2, 1, 1'b0);
      goruntu_kontrol(1'b0);
      kontrol("tasma_var", 32'(tasma_o), 32'd1);
      kontrol("dusen_kelime", 32'(yazma_say < NW), 32'd1);

      // Reset mid-frame with a request outstanding
      adim(1'b1, 1'b0, 8'd0, 1'b0);
      for (int j = 0; j < 12; j++) adim(1'b0, 1'b1, 8'($urandom), 1'b0);
      kontrol("istek_once", 32'(bellek_istek_o), 32'd1);
      rstn_i = 1'b0;
      #1;
      kontrol("orst_istek", 32'(bellek_istek_o), 32'd0);
      kontrol("orst_adres", bellek_adres_o, TABAN);
      kontrol("orst_veri", bellek_veri_o, 32'd0);
      kontrol("orst_sayac", 32'(piksel_sayac_o), 32'd0);
      kontrol("orst_tasma", 32'(tasma_o), 32'd0);
      m_faz = 0;
      modeli_temizle();
      @(posedge clk_i);
      #1;
      rstn_i = 1'b1;

      // Random gaps, random readiness, ignored mid-frame starts
      cerceve_kos(3, 1, 1'b1);
      goruntu_kontrol(!m_tasma);

      // All-0xFF frame
      cerceve_kos(0, 2, 1'b0);
      goruntu_kontrol(1'b1);
`ifdef TOPLAYICI_SAGLAMA_EN
      kontrol("saglama_model", saglama_o, m_sag);
      kontrol("saglama_sabit", saglama_o, 32'(N * 255));
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_kontrol, n_hata);
      $finish;
   end

endmodule
